stop_watch_ctrl: RTL and testbench
==================================

Name: stop_watch_ctrl

Overview:
Control FSM that sequences the three-digit BCD stopwatch datapath from three debounced push-button levels.
- Detects rising edges on start/stop, lap and clear.
- Drives the datapath go and clr inputs.
- Owns a registered display copy of the count, which it can freeze for lap (split) times while counting continues.
- Sits between the debouncers and the stopwatch/seven-segment display path.

Parameters:
DW, 4, width of one BCD digit
CLR_CYCLES, 2, number of cycles clr is held high per clear request (1..15)

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
btn_ss  input  1  debounced, synchronous start/stop level
btn_lap  input  1  debounced, synchronous lap level
btn_clr  input  1  debounced, synchronous clear level
d2  input  DW  live hundreds digit from datapath
d1  input  DW  live tens digit from datapath
d0  input  DW  live units digit from datapath
go  output  1  count-enable to datapath
clr  output  1  synchronous clear to datapath
disp2  output  DW  displayed hundreds digit
disp1  output  DW  displayed tens digit
disp0  output  DW  displayed units digit
frozen  output  1  display is holding a lap value

Behaviour:
- One clock domain. Reset is asynchronous, active-low (reset_n).
- Reset values: state IDLE; go=0; clr=0; disp2..0=0; frozen=0; clear counter 0.
- Edge detect: each button has a previous-value register that resets to 1, so a button held through reset produces no event. ev_x = btn_x & ~prev_x, valid for one cycle.
- State register is one-hot or binary. go, clr and frozen are registered and change on the same edge as the state. Latency is one clock from the cycle the event is sampled.
- States and outputs:
  - IDLE: go=0, frozen=0
  - RUN: go=1, frozen=0
  - PAUSE: go=0, frozen=0
  - LAP_RUN: go=1, frozen=1
  - LAP_PAUSE: go=0, frozen=1
  - CLEAR: clr=1, go=0, frozen=0
- Transitions (ev_clr has highest priority in every state):
  - IDLE: ss -> RUN; lap ignored.
  - RUN: ss -> PAUSE; lap -> LAP_RUN (capture).
  - PAUSE: ss -> RUN; lap ignored.
  - LAP_RUN: ss -> LAP_PAUSE; lap -> RUN (release display).
  - LAP_PAUSE: ss -> LAP_RUN; lap -> PAUSE (release display).
  - Any state: clr -> CLEAR, clear counter loaded with CLR_CYCLES-1.
  - CLEAR: counter decrements each cycle. At 0 -> IDLE. ev_clr inside CLEAR reloads the counter. ss/lap events inside CLEAR are dropped.
- Simultaneous events in one cycle: clr > ss > lap. The lower-priority events are discarded, not queued.
- Display:
  - When the next state is not frozen, disp <= {d2,d1,d0} every cycle (one-cycle lag behind the datapath).
  - On a lap capture, disp latches the d value present in the event cycle, then holds while frozen=1.
  - Entering CLEAR forces disp <= 0 on the same edge.
- reset_n asserted mid-run: go drops immediately (asynchronously). The datapath count is not cleared by this block; software/board reset clears it.

Optional Feature:
Macro STOP_AT_MAX_EN.
- Defined:
  - In RUN or LAP_RUN, when d2=d1=d0=9, next state is PAUSE or LAP_PAUSE respectively, so go falls one cycle after 999 is observed and the count stays at 999.
  - ev_ss in PAUSE/LAP_PAUSE is ignored while the count reads 999; only clear leaves that condition.
- Undefined:
  - No comparison logic is built.
  - The datapath wraps 999 -> 000 and the controller keeps running.

Test Plan:
- Reset: reset_n low with all buttons high, release -> go=0, clr=0, disp=000, no event, state IDLE.
- Start/stop: btn_ss 0->1 at cycle 10 -> go=1 from cycle 11. Second press -> go=0 one cycle after that event. Holding btn_ss high produces only one event.
- Lap: running with d=042, press lap -> frozen=1, disp holds 042 while d advances to 050. Press lap again -> frozen=0, disp tracks d (050) next cycle.
- Clear priority: btn_ss and btn_clr rise in the same cycle while RUN -> clr=1 for exactly 2 cycles (CLR_CYCLES=2), go=0, disp=000, then IDLE. A second clr press in CLEAR extends the clr pulse.
- Lap-pause path: RUN -> lap -> ss gives go=0, frozen=1. Then lap gives PAUSE, frozen=0. Then ss gives RUN, go=1.
- STOP_AT_MAX_EN: drive d=999 in RUN -> go=0 next cycle and ss press ignored. Clear -> IDLE. Without the macro, go stays 1 at d=999.

Source files
------------

// File: rtl/stop_watch_ctrl_if.sv
// stop_watch_ctrl_if: button levels, live digits and control/display outputs of the stopwatch controller
interface stop_watch_ctrl_if #(parameter int DW = 4);
    logic          btn_ss;
    logic          btn_lap;
    logic          btn_clr;
    logic [DW-1:0] d2;
    logic [DW-1:0] d1;
    logic [DW-1:0] d0;
    logic          go;
    logic          clr;
    logic [DW-1:0] disp2;
    logic [DW-1:0] disp1;
    logic [DW-1:0] disp0;
    logic          frozen;
    modport slave (
        input  btn_ss, btn_lap, btn_clr, d2, d1, d0,
        output go, clr, disp2, disp1, disp0, frozen
    );
    modport master (
        output btn_ss, btn_lap, btn_clr, d2, d1, d0,
        input  go, clr, disp2, disp1, disp0, frozen
    );
endinterface

// File: rtl/stop_watch_ctrl.sv
// stop_watch_ctrl: stopwatch control FSM with lap display freeze; STOP_AT_MAX_EN halts counting at 999
module stop_watch_ctrl #(
    parameter int DW         = 4,
    parameter int CLR_CYCLES = 2
) (
    input logic              clk,
    input logic              reset_n,
    stop_watch_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RUN, PAUSE, LAP_RUN, LAP_PAUSE, CLEAR} state_t;
    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic [2:0] prev, btn, ev;
    logic       ev_clr, ev_ss, ev_lap, at_max, go_nx, frozen_nx;
    assign btn    = {bus.btn_clr, bus.btn_ss, bus.btn_lap};
    assign ev     = btn & ~prev;
    assign ev_clr = ev[2];
    assign ev_ss  = ev[1];
    assign ev_lap = ev[0];
`ifdef STOP_AT_MAX_EN
    assign at_max = (bus.d2 == DW'(9)) && (bus.d1 == DW'(9)) && (bus.d0 == DW'(9));
`else
    assign at_max = 1'b0;
`endif
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (ev_clr) begin
            state_nx = CLEAR;
            cnt_nx   = 4'(CLR_CYCLES - 1);
        end else begin
            case (state)
                IDLE:      state_nx = ev_ss ? RUN : IDLE;
                RUN:       state_nx = (ev_ss || at_max) ? PAUSE : ev_lap ? LAP_RUN : RUN;
                PAUSE:     state_nx = (ev_ss && !at_max) ? RUN : PAUSE;
                LAP_RUN:   state_nx = (ev_ss || at_max) ? LAP_PAUSE : ev_lap ? RUN : LAP_RUN;
                LAP_PAUSE: state_nx = (ev_ss && !at_max) ? LAP_RUN : ev_lap ? PAUSE : LAP_PAUSE;
                CLEAR: begin
                    state_nx = (cnt == 4'd0) ? IDLE : CLEAR;
                    cnt_nx   = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
                end
                default:   state_nx = IDLE;
            endcase
        end
    end
    assign go_nx     = (state_nx == RUN) || (state_nx == LAP_RUN);
    assign frozen_nx = (state_nx == LAP_RUN) || (state_nx == LAP_PAUSE);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            prev       <= 3'b111;
            bus.go     <= 1'b0;
            bus.clr    <= 1'b0;
            bus.frozen <= 1'b0;
            bus.disp2  <= '0;
            bus.disp1  <= '0;
            bus.disp0  <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            prev       <= btn;
            bus.go     <= go_nx;
            bus.clr    <= (state_nx == CLEAR);
            bus.frozen <= frozen_nx;
            // capture on entry to a lap state, then hold until released
            if (state_nx == CLEAR) begin
                bus.disp2 <= '0;
                bus.disp1 <= '0;
                bus.disp0 <= '0;
            end else if (!frozen_nx || !bus.frozen) begin
                bus.disp2 <= bus.d2;
                bus.disp1 <= bus.d1;
                bus.disp0 <= bus.d0;
            end
        end
    end
endmodule

// File: tb/tb_stop_watch_ctrl.sv
// tb_stop_watch_ctrl: directed checks of events, lap freeze, clear priority/extension and max-count handling
module tb_stop_watch_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    stop_watch_ctrl_if #(.DW(4)) sw ();
    stop_watch_ctrl #(.DW(4), .CLR_CYCLES(2)) dut (.clk(clk), .reset_n(reset_n), .bus(sw));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic set_d(input logic [11:0] v);
        {sw.d2, sw.d1, sw.d0} = v;
    endtask
    function automatic logic [11:0] disp();
        return {sw.disp2, sw.disp1, sw.disp0};
    endfunction
    initial begin
        {sw.btn_ss, sw.btn_lap, sw.btn_clr} = 3'b111;
        set_d(12'h000);
        tick(); tick();
        chk("rst_go", sw.go, 1'b0);
        chk("rst_clr", sw.clr, 1'b0);
        chk("rst_frozen", sw.frozen, 1'b0);
        chk("rst_disp", disp(), 12'h000);
        reset_n = 1'b1;
        tick(); tick();
        chk("held_no_event_go", sw.go, 1'b0);
        chk("held_no_event_clr", sw.clr, 1'b0);
        {sw.btn_ss, sw.btn_lap, sw.btn_clr} = 3'b000;
        tick();
        sw.btn_ss = 1'b1; tick();
        chk("start_go", sw.go, 1'b1);
        tick(); tick(); tick();
        chk("hold_ss_one_event", sw.go, 1'b1);
        sw.btn_ss = 1'b0; tick();
        set_d(12'h042); tick();
        chk("track_disp", disp(), 12'h042);
        sw.btn_lap = 1'b1; tick();
        chk("lap_frozen", sw.frozen, 1'b1);
        chk("lap_disp", disp(), 12'h042);
        sw.btn_lap = 1'b0; set_d(12'h050); tick(); tick();
        chk("lap_hold_disp", disp(), 12'h042);
        chk("lap_go", sw.go, 1'b1);
        sw.btn_lap = 1'b1; tick();
        chk("release_frozen", sw.frozen, 1'b0);
        chk("release_disp", disp(), 12'h050);
        sw.btn_lap = 1'b0; tick();
        sw.btn_ss = 1'b1; sw.btn_clr = 1'b1; tick();
        chk("clrpri_clr", sw.clr, 1'b1);
        chk("clrpri_go", sw.go, 1'b0);
        chk("clrpri_disp", disp(), 12'h000);
        sw.btn_ss = 1'b0; sw.btn_clr = 1'b0; set_d(12'h000); tick();
        chk("clr_cycle2", sw.clr, 1'b1);
        tick();
        chk("clr_done", sw.clr, 1'b0);
        chk("idle_go", sw.go, 1'b0);
        sw.btn_clr = 1'b1; tick();
        chk("ext_c1", sw.clr, 1'b1);
        sw.btn_clr = 1'b0; tick();
        chk("ext_c2", sw.clr, 1'b1);
        sw.btn_clr = 1'b1; tick();
        chk("ext_c3", sw.clr, 1'b1);
        sw.btn_clr = 1'b0; tick();
        chk("ext_c4", sw.clr, 1'b1);
        tick();
        chk("ext_done", sw.clr, 1'b0);
        sw.btn_ss = 1'b1; tick();
        chk("lp_run_go", sw.go, 1'b1);
        sw.btn_ss = 1'b0; tick();
        sw.btn_lap = 1'b1; tick();
        chk("lp_laprun_frozen", sw.frozen, 1'b1);
        sw.btn_lap = 1'b0; tick();
        sw.btn_ss = 1'b1; tick();
        chk("lp_lappause_go", sw.go, 1'b0);
        chk("lp_lappause_frozen", sw.frozen, 1'b1);
        sw.btn_ss = 1'b0; tick();
        sw.btn_lap = 1'b1; tick();
        chk("lp_pause_frozen", sw.frozen, 1'b0);
        chk("lp_pause_go", sw.go, 1'b0);
        sw.btn_lap = 1'b0; tick();
        sw.btn_ss = 1'b1; tick();
        chk("lp_rerun_go", sw.go, 1'b1);
        sw.btn_ss = 1'b0; tick();
        set_d(12'h999); tick();
`ifdef STOP_AT_MAX_EN
        chk("max_go", sw.go, 1'b0);
        sw.btn_ss = 1'b1; tick();
        chk("max_ss_ignored", sw.go, 1'b0);
`else
        chk("max_go", sw.go, 1'b1);
        tick();
        chk("max_keeps_running", sw.go, 1'b1);
        sw.btn_ss = 1'b1; tick();
        chk("max_ss_pause", sw.go, 1'b0);
`endif
        sw.btn_ss = 1'b0; tick();
        sw.btn_clr = 1'b1; tick();
        chk("max_clr", sw.clr, 1'b1);
        sw.btn_clr = 1'b0; set_d(12'h000); tick(); tick();
        chk("max_idle_clr", sw.clr, 1'b0);
        chk("max_idle_go", sw.go, 1'b0);
        sw.btn_ss = 1'b1; tick();
        sw.btn_ss = 1'b0;
        chk("async_pre_go", sw.go, 1'b1);
        #2 reset_n = 1'b0;
        #1 chk("async_go", sw.go, 1'b0);
        tick();
        reset_n = 1'b1; tick();
        chk("async_after_go", sw.go, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
